// File: rtl/cr_pmp_chk_arb.sv
// Arbitrates IFU/LSU access to a shared PMP comparator datapath.
// It registers the lowest-index-hit deny result back to whichever requester owns the check.
module cr_pmp_chk_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int REGION_NUM = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ifu_pmp_req,
  input  logic [ADDR_WIDTH-1:0] ifu_pmp_addr,
  input  logic [3:0]            ifu_pmp_prot,
  output logic                  pmp_ifu_gnt,
  output logic                  pmp_ifu_rsp_vld,
  output logic                  pmp_ifu_deny,
  input  logic                  lsu_pmp_req,
  input  logic [ADDR_WIDTH-1:0] lsu_pmp_addr,
  input  logic                  lsu_pmp_write,
  output logic                  pmp_lsu_gnt,
  output logic                  pmp_lsu_rsp_vld,
  output logic                  pmp_lsu_deny,
  input  logic                  cp0_pmp_cfg_wr,
  output logic                  arb_comp_vld,
  output logic [ADDR_WIDTH-1:0] arb_comp_addr,
  output logic                  arb_comp_is_ifu,
  output logic                  arb_comp_write,
  output logic [3:0]            arb_comp_prot,
  input  logic [REGION_NUM-1:0] comp_arb_hit,
  input  logic [REGION_NUM-1:0] comp_arb_deny_region,
  input  logic                  comp_arb_no_hit_deny
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          cfg_stall;
  logic          grant_blk;
  logic          ifu_win;
  logic          gnt_any;
  logic          deny_enc;

  // A CSR write and the cycle after it must not launch a check, so no grant sees half-updated config.
  assign grant_blk   = cp0_pmp_cfg_wr | cfg_stall;
  assign ifu_win     = ifu_pmp_req & (~lsu_pmp_req | (starve_cnt == CW'(STARVE_MAX)));
  assign pmp_ifu_gnt = ~grant_blk & ifu_win;
  assign pmp_lsu_gnt = ~grant_blk & lsu_pmp_req & ~ifu_win;
  assign gnt_any     = pmp_ifu_gnt | pmp_lsu_gnt;

  // Walk from the top down so that the lowest-index hit is the last one assigned and therefore wins.
  always_comb begin
    deny_enc = comp_arb_no_hit_deny;
    for (int i = REGION_NUM - 1; i >= 0; i--) begin
      if (comp_arb_hit[i]) deny_enc = comp_arb_deny_region[i];
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      starve_cnt      <= '0;
      cfg_stall       <= 1'b0;
      arb_comp_vld    <= 1'b0;
      arb_comp_addr   <= '0;
      arb_comp_is_ifu <= 1'b0;
      arb_comp_write  <= 1'b0;
      arb_comp_prot   <= 4'd0;
      pmp_ifu_rsp_vld <= 1'b0;
      pmp_ifu_deny    <= 1'b0;
      pmp_lsu_rsp_vld <= 1'b0;
      pmp_lsu_deny    <= 1'b0;
    end else begin
      cfg_stall <= cp0_pmp_cfg_wr;

      if (pmp_ifu_gnt || !ifu_pmp_req) begin
        starve_cnt <= '0;
      end else if (pmp_lsu_gnt && (starve_cnt != CW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CW'(1);
      end

      arb_comp_vld <= gnt_any;
      if (gnt_any) begin
        arb_comp_addr   <= pmp_ifu_gnt ? ifu_pmp_addr : lsu_pmp_addr;
        arb_comp_is_ifu <= pmp_ifu_gnt;
        arb_comp_write  <= pmp_lsu_gnt & lsu_pmp_write;
        arb_comp_prot   <= pmp_ifu_gnt ? ifu_pmp_prot : 4'd0;
      end

      pmp_ifu_rsp_vld <= arb_comp_vld & arb_comp_is_ifu;
      pmp_ifu_deny    <= arb_comp_vld & arb_comp_is_ifu & deny_enc;
      pmp_lsu_rsp_vld <= arb_comp_vld & ~arb_comp_is_ifu;
      pmp_lsu_deny    <= arb_comp_vld & ~arb_comp_is_ifu & deny_enc;
    end
  end

endmodule
